// File: rtl/stream_matrix_encoder_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared types and helpers for stream_matrix_encoder.
//   state_t        : encoder FSM states (IDLE / ENCODE / DONE)
//   ENC_DEFAULT_G  : reset value of the 4x8 generator, row i at [i*8 +: 8]
//   gf2_encode()   : GF(2) vector-matrix product of one chunk with a generator
// ---------------------------------------------------------------------------
package enc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] ENC_DEFAULT_G = 32'h78E4D2B1;

    // Upper bounds for the helper's fixed argument widths; callers zero-pad.
    localparam int K_MAX  = 8;
    localparam int N_MAX  = 16;
    localparam int G_MAX  = K_MAX * N_MAX;
    localparam int GIDX_W = $clog2(G_MAX);

    // codeword[j] = XOR over i < k of (chunk[i] & g[i*n + j]); no carries.
    function automatic logic [N_MAX-1:0] gf2_encode(
        input logic [K_MAX-1:0] chunk,
        input logic [G_MAX-1:0] g,
        input int               k,
        input int               n
    );
        logic [N_MAX-1:0]  cw;
        logic [GIDX_W-1:0] idx;
        cw = '0;
        for (int i = 0; i < K_MAX; i++) begin
            for (int j = 0; j < N_MAX; j++) begin
                idx = GIDX_W'(i * n + j);
                if (i < k && j < n) begin
                    cw[4'(j)] = cw[4'(j)] ^ (chunk[3'(i)] & g[idx]);
                end
            end
        end
        return cw;
    endfunction

endpackage

// File: rtl/stream_matrix_encoder_if.sv
// ---------------------------------------------------------------------------
// stream_matrix_encoder_if
// Input-word and output-buffer handshakes of stream_matrix_encoder.
//   in_valid/in_ready/data_in    : word stream into the encoder
//   out_valid/out_ready/enc_flat : encoded buffer out of the encoder
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid && ready are both high. Once valid is raised it holds, with its
// payload stable, until that transfer; ready may be raised or lowered freely
// and the producer never waits on ready before asserting valid.
// Modports: master = word producer / buffer consumer, slave = the encoder.
// ---------------------------------------------------------------------------
interface stream_matrix_encoder_if #(
    parameter int DATA_W = 64,
    parameter int K      = 4,
    parameter int N      = 8
);
    localparam int CHUNKS = DATA_W / K;

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   data_in;
    logic                out_valid;
    logic                out_ready;
    logic [CHUNKS*N-1:0] enc_flat;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, enc_flat
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, enc_flat
    );
endinterface

// File: rtl/stream_matrix_encoder_lane.sv
// ---------------------------------------------------------------------------
// enc_lane
// Combinational encoder for one chunk: cw = chunk x G over GF(2).
//   chunk : K data bits
//   g     : K x N generator, row i at [i*N +: N]
//   cw    : N-bit codeword
// ---------------------------------------------------------------------------
module enc_lane
    import enc_pkg::*;
#(
    parameter int K = 4,
    parameter int N = 8
) (
    input  logic [K-1:0]   chunk,
    input  logic [K*N-1:0] g,
    output logic [N-1:0]   cw
);
    logic [K_MAX-1:0] chunk_pad;
    logic [G_MAX-1:0] g_pad;
    logic [N_MAX-1:0] cw_full;

    always_comb begin
        chunk_pad          = '0;
        chunk_pad[K-1:0]   = chunk;
        g_pad              = '0;
        g_pad[K*N-1:0]     = g;
        cw_full            = gf2_encode(chunk_pad, g_pad, K, N);
    end

    assign cw = N'(cw_full);
endmodule

// File: rtl/stream_matrix_encoder.sv
// ---------------------------------------------------------------------------
// stream_matrix_encoder
// Latches a DATA_W-bit word, encodes LANES K-bit chunks per cycle into N-bit
// codewords with a KxN GF(2) generator, and presents the full buffer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : in_valid/in_ready/data_in, out_valid/out_ready/enc_flat
//   dbg_state   : current FSM state
//   gen_we, gen_row, gen_data : generator row write, only when
//                 ENC_GEN_LOAD_EN is defined; accepted in IDLE only
// Without ENC_GEN_LOAD_EN the generator is the constant DEFAULT_G.
// ---------------------------------------------------------------------------
module stream_matrix_encoder
    import enc_pkg::*;
#(
    parameter int             DATA_W    = 64,
    parameter int             K         = 4,
    parameter int             N         = 8,
    parameter int             LANES     = 2,
    parameter logic [K*N-1:0] DEFAULT_G = ENC_DEFAULT_G
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef ENC_GEN_LOAD_EN
    input  logic                   gen_we,
    input  logic [$clog2(K)-1:0]   gen_row,
    input  logic [N-1:0]           gen_data,
`endif
    stream_matrix_encoder_if.slave bus,
    output state_t                 dbg_state
);
    localparam int CHUNKS = DATA_W / K;
    localparam int IDX_W  = $clog2(CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - LANES);

    state_t             state_q, state_d;
    logic               accept;
    logic               enc_en;
    logic [IDX_W-1:0]   chunk_idx_q;
    logic [DATA_W-1:0]  data_q;
    logic [K-1:0]       data_chunks [CHUNKS];
    logic [N-1:0]       enc_q       [CHUNKS];
    logic [N-1:0]       lane_cw     [LANES];
    logic [K*N-1:0]     g_cur;

    // ---------------- generator ----------------
`ifdef ENC_GEN_LOAD_EN
    localparam int ROW_W = $clog2(K);
    logic [K*N-1:0] g_q;

    // Writes only land in IDLE so a word never sees a half-updated matrix.
    // A write on the accepting edge is visible because encoding starts later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q <= DEFAULT_G;
        end else if (gen_we && state_q == IDLE) begin
            for (int r = 0; r < K; r++) begin
                if (gen_row == ROW_W'(r)) g_q[r*N +: N] <= gen_data;
            end
        end
    end
    assign g_cur = g_q;
`else
    assign g_cur = DEFAULT_G;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        enc_en        = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = ENCODE;
            end
            ENCODE: begin
                enc_en = 1'b1;
                if (chunk_idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign dbg_state = state_q;

    // ---------------- datapath ----------------
    for (genvar c = 0; c < CHUNKS; c++) begin : g_split
        assign data_chunks[c] = data_q[c*K +: K];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        enc_lane #(.K(K), .N(N)) u_lane (
            .chunk (data_chunks[chunk_idx_q + IDX_W'(l)]),
            .g     (g_cur),
            .cw    (lane_cw[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            chunk_idx_q <= '0;
            for (int c = 0; c < CHUNKS; c++) enc_q[c] <= '0;
        end else if (accept) begin
            data_q      <= bus.data_in;
            chunk_idx_q <= '0;
        end else if (enc_en) begin
            chunk_idx_q <= chunk_idx_q + IDX_W'(LANES);
            // Chunk c belongs to the group starting at c - c%LANES, lane c%LANES.
            for (int c = 0; c < CHUNKS; c++) begin
                if (chunk_idx_q == IDX_W'(c - c % LANES)) enc_q[c] <= lane_cw[c % LANES];
            end
        end
    end

    always_comb begin
        bus.enc_flat = '0;
        for (int c = 0; c < CHUNKS; c++) bus.enc_flat[c*N +: N] = enc_q[c];
    end
endmodule
